// File: rtl/reli_mux.sv
// reli_mux: packet-level 3:1 AXI-Stream merger (buf/ctl/net -> MAC).
// Round-robin grant held until tlast, followed by a registered 2-entry skid output.
//
// state  | meaning
// IDLE   | no grant; pick first valid port scanning from rr_last+1
// ACTIVE | grant locked to one port until its tlast beat is accepted

module reli_mux #(
    parameter int AXIS_DATA_WIDTH = 128,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
    parameter int AXIS_USER_WIDTH = 72
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_buf_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_buf_tkeep,
    input  logic [AXIS_USER_WIDTH-1:0] s_axis_buf_tuser,
    input  logic                       s_axis_buf_tvalid,
    input  logic                       s_axis_buf_tlast,
    output logic                       s_axis_buf_tready,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_ctl_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_ctl_tkeep,
    input  logic [AXIS_USER_WIDTH-1:0] s_axis_ctl_tuser,
    input  logic                       s_axis_ctl_tvalid,
    input  logic                       s_axis_ctl_tlast,
    output logic                       s_axis_ctl_tready,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_net_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_net_tkeep,
    input  logic [AXIS_USER_WIDTH-1:0] s_axis_net_tuser,
    input  logic                       s_axis_net_tvalid,
    input  logic                       s_axis_net_tlast,
    output logic                       s_axis_net_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [AXIS_USER_WIDTH-1:0] m_axis_tuser,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic [1:0]                 m_axis_tid,
    output logic                       busy
);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    state_t     r_state, w_state_next;
    logic [1:0] r_grant, w_grant_next;
    logic [1:0] r_rr_last, w_rr_last_next;
    logic [1:0] w_sel;
    logic [2:0] w_req;
    logic       r_ready_int;
    logic       w_ready_int_early;

    logic [AXIS_DATA_WIDTH-1:0] w_in_tdata;
    logic [AXIS_KEEP_WIDTH-1:0] w_in_tkeep;
    logic [AXIS_USER_WIDTH-1:0] w_in_tuser;
    logic                       w_in_tvalid, w_in_tlast, w_in_beat;

    logic [AXIS_DATA_WIDTH-1:0] r_m_tdata, r_t_tdata;
    logic [AXIS_KEEP_WIDTH-1:0] r_m_tkeep, r_t_tkeep;
    logic [AXIS_USER_WIDTH-1:0] r_m_tuser, r_t_tuser;
    logic                       r_m_tlast, r_t_tlast;
    logic [1:0]                 r_m_tid, r_t_tid;
    logic                       r_m_tvalid, r_t_tvalid;
    logic                       w_m_tvalid_next, w_t_tvalid_next;
    logic                       w_to_out, w_to_temp, w_temp_to_out;

    assign w_req = {s_axis_net_tvalid, s_axis_ctl_tvalid, s_axis_buf_tvalid};

    always_comb begin
        w_sel = 2'd0;
        case (r_rr_last)
            2'd0: begin
                if (w_req[1])      w_sel = 2'd1;
                else if (w_req[2]) w_sel = 2'd2;
                else               w_sel = 2'd0;
            end
            2'd1: begin
                if (w_req[2])      w_sel = 2'd2;
                else if (w_req[0]) w_sel = 2'd0;
                else               w_sel = 2'd1;
            end
            default: begin
                if (w_req[0])      w_sel = 2'd0;
                else if (w_req[1]) w_sel = 2'd1;
                else               w_sel = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_in_tdata  = s_axis_net_tdata;
        w_in_tkeep  = s_axis_net_tkeep;
        w_in_tuser  = s_axis_net_tuser;
        w_in_tvalid = s_axis_net_tvalid;
        w_in_tlast  = s_axis_net_tlast;
        case (r_grant)
            2'd0: begin
                w_in_tdata  = s_axis_buf_tdata;
                w_in_tkeep  = s_axis_buf_tkeep;
                w_in_tuser  = s_axis_buf_tuser;
                w_in_tvalid = s_axis_buf_tvalid;
                w_in_tlast  = s_axis_buf_tlast;
            end
            2'd1: begin
                w_in_tdata  = s_axis_ctl_tdata;
                w_in_tkeep  = s_axis_ctl_tkeep;
                w_in_tuser  = s_axis_ctl_tuser;
                w_in_tvalid = s_axis_ctl_tvalid;
                w_in_tlast  = s_axis_ctl_tlast;
            end
            default: ;
        endcase
    end

    assign w_in_beat = (r_state == ST_ACTIVE) && w_in_tvalid && r_ready_int;

    assign s_axis_buf_tready = (r_state == ST_ACTIVE) && (r_grant == 2'd0) && r_ready_int;
    assign s_axis_ctl_tready = (r_state == ST_ACTIVE) && (r_grant == 2'd1) && r_ready_int;
    assign s_axis_net_tready = (r_state == ST_ACTIVE) && (r_grant == 2'd2) && r_ready_int;
    assign busy              = (r_state == ST_ACTIVE);

    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_rr_last_next = r_rr_last;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_grant_next = w_sel;
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_in_beat && w_in_tlast) begin
                    w_state_next   = ST_IDLE;
                    w_rr_last_next = r_grant;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= 2'd0;
            r_rr_last <= 2'd2;
        end else begin
            r_state   <= w_state_next;
            r_grant   <= w_grant_next;
            r_rr_last <= w_rr_last_next;
        end
    end

    // Ready is registered, so one beat may arrive after a stall begins; temp absorbs it.
    assign w_ready_int_early = m_axis_tready || (!r_t_tvalid && (!r_m_tvalid || !w_in_beat));

    always_comb begin
        w_m_tvalid_next = r_m_tvalid;
        w_t_tvalid_next = r_t_tvalid;
        w_to_out        = 1'b0;
        w_to_temp       = 1'b0;
        w_temp_to_out   = 1'b0;
        if (r_ready_int) begin
            if (m_axis_tready || !r_m_tvalid) begin
                w_m_tvalid_next = w_in_beat;
                w_to_out        = 1'b1;
            end else begin
                w_t_tvalid_next = w_in_beat;
                w_to_temp       = 1'b1;
            end
        end else if (m_axis_tready) begin
            w_m_tvalid_next = r_t_tvalid;
            w_t_tvalid_next = 1'b0;
            w_temp_to_out   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_m_tvalid  <= 1'b0;
            r_t_tvalid  <= 1'b0;
            r_ready_int <= 1'b0;
        end else begin
            r_m_tvalid  <= w_m_tvalid_next;
            r_t_tvalid  <= w_t_tvalid_next;
            r_ready_int <= w_ready_int_early;
        end
    end

    always_ff @(posedge clk) begin
        if (w_to_out) begin
            r_m_tdata <= w_in_tdata;
            r_m_tkeep <= w_in_tkeep;
            r_m_tuser <= w_in_tuser;
            r_m_tlast <= w_in_tlast;
            r_m_tid   <= r_grant;
        end else if (w_temp_to_out) begin
            r_m_tdata <= r_t_tdata;
            r_m_tkeep <= r_t_tkeep;
            r_m_tuser <= r_t_tuser;
            r_m_tlast <= r_t_tlast;
            r_m_tid   <= r_t_tid;
        end
        if (w_to_temp) begin
            r_t_tdata <= w_in_tdata;
            r_t_tkeep <= w_in_tkeep;
            r_t_tuser <= w_in_tuser;
            r_t_tlast <= w_in_tlast;
            r_t_tid   <= r_grant;
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tid    = r_m_tid;
    assign m_axis_tvalid = r_m_tvalid;

endmodule

// File: tb/tb_reli_mux.sv
// Bench for reli_mux: directed scenarios plus randomized traffic, checked
// against a packet-order reference model built from per-port packet queues.

module tb_reli_mux;
    localparam int DW = 128;
    localparam int KW = 16;
    localparam int UW = 72;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        logic [1:0]    id;
        int            gap;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] sd [3];
    logic [KW-1:0] sk [3];
    logic [UW-1:0] su [3];
    logic [2:0]    sv, sl;
    wire  [2:0]    sr;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid, m_tlast, m_tready, busy;
    logic [1:0]    m_tid;

    reli_mux #(.AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_USER_WIDTH(UW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_buf_tdata(sd[0]), .s_axis_buf_tkeep(sk[0]), .s_axis_buf_tuser(su[0]),
        .s_axis_buf_tvalid(sv[0]), .s_axis_buf_tlast(sl[0]), .s_axis_buf_tready(sr[0]),
        .s_axis_ctl_tdata(sd[1]), .s_axis_ctl_tkeep(sk[1]), .s_axis_ctl_tuser(su[1]),
        .s_axis_ctl_tvalid(sv[1]), .s_axis_ctl_tlast(sl[1]), .s_axis_ctl_tready(sr[1]),
        .s_axis_net_tdata(sd[2]), .s_axis_net_tkeep(sk[2]), .s_axis_net_tuser(su[2]),
        .s_axis_net_tvalid(sv[2]), .s_axis_net_tlast(sl[2]), .s_axis_net_tready(sr[2]),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .m_axis_tid(m_tid), .busy(busy)
    );

    beat_t q0[$], q1[$], q2[$], exp_q[$];
    bit    rdy_pat[$];
    int    total = 0, bad = 0, cyc = 0, last_cyc = 0, rdy_mode = 1;
    int    gap_left [3];
    bit    chk_cad = 0, have_prev = 0, prev_last = 0;

    function automatic int qsz(input int p);
        case (p)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic beat_t qfront(input int p);
        case (p)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void qpop(input int p);
        case (p)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void qpush(input int p, input beat_t b);
        case (p)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    function automatic logic next_rdy();
        if (rdy_pat.size() > 0) return rdy_pat.pop_front();
        case (rdy_mode)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return ($urandom_range(0, 9) < 7);
        endcase
    endfunction

    // Packets are queued on the source and appended to the expected output
    // stream in the order the caller knows round-robin must produce them.
    task automatic add_pkt(input int p, input int len, input int base,
                           input bit rnd_gap, input int gap_at, input int gap_len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            if (base >= 0) b.d = DW'(base + i);
            else           b.d = {$urandom, $urandom, $urandom, $urandom};
            b.k  = KW'($urandom);
            b.u  = {8'($urandom), $urandom, $urandom};
            b.l  = (i == len - 1);
            b.id = 2'(p);
            if (i == gap_at)          b.gap = gap_len;
            else if (rnd_gap && i > 0) b.gap = int'($urandom_range(0, 2));
            else                       b.gap = 0;
            qpush(p, b);
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_port(input int p);
        beat_t b;
        if (sv[p]) return;
        if (qsz(p) == 0) return;
        if (gap_left[p] < 0) gap_left[p] = qfront(p).gap;
        if (gap_left[p] > 0) begin
            gap_left[p]--;
        end else begin
            b = qfront(p);
            sd[p] = b.d; sk[p] = b.k; su[p] = b.u; sl[p] = b.l;
            sv[p] = 1'b1;
            gap_left[p] = -1;
        end
    endtask

    task automatic drive_all();
        for (int p = 0; p < 3; p++) drive_port(p);
        m_tready = next_rdy();
    endtask

    task automatic check_out();
        beat_t e;
        total++;
        assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL extra_beat: got tid=%0d data=%h, expected no beat", m_tid, m_tdata);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            assert ({m_tdata, m_tkeep, m_tuser, m_tlast, m_tid} === {e.d, e.k, e.u, e.l, e.id}) else begin
                bad++;
                $error("FAIL out_beat: got tid=%0d last=%0b data=%h keep=%h user=%h, exp tid=%0d last=%0b data=%h keep=%h user=%h",
                       m_tid, m_tlast, m_tdata, m_tkeep, m_tuser, e.id, e.l, e.d, e.k, e.u);
            end
        end
        if (chk_cad && have_prev) begin
            total++;
            assert ((cyc - last_cyc) == (prev_last ? 2 : 1)) else begin
                bad++;
                $error("FAIL cadence: got spacing %0d, exp %0d", cyc - last_cyc, prev_last ? 2 : 1);
            end
        end
        have_prev = 1;
        last_cyc  = cyc;
        prev_last = m_tlast;
    endtask

    task automatic cycle();
        logic [2:0]          hs;
        logic                ohs, stalled, filled;
        logic [DW+KW+UW+2:0] held;
        hs      = rst ? (sv & sr) : 3'b000;
        ohs     = rst & m_tvalid & m_tready;
        stalled = rst & m_tvalid & ~m_tready;
        filled  = stalled & (|hs);
        held    = {m_tdata, m_tkeep, m_tuser, m_tlast, m_tid};
        if (ohs) check_out();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (stalled) begin
            total++;
            assert (m_tvalid === 1'b1 && {m_tdata, m_tkeep, m_tuser, m_tlast, m_tid} === held) else begin
                bad++;
                $error("FAIL stall_hold: got valid=%0b data=%h, exp valid=1 data=%h", m_tvalid, m_tdata, held[DW+KW+UW+2:KW+UW+3]);
            end
        end
        if (filled) begin
            total++;
            assert (sr === 3'b000) else begin
                bad++;
                $error("FAIL temp_full_ready: got treadys=%b, exp 000", sr);
            end
        end
        if (|hs) begin
            total++;
            assert (m_tvalid === 1'b1) else begin
                bad++;
                $error("FAIL latency: got m_tvalid=%0b after input beat, exp 1", m_tvalid);
            end
        end
        for (int p = 0; p < 3; p++) begin
            if (hs[p]) begin
                qpop(p);
                sv[p] = 1'b0;
            end
        end
        drive_all();
    endtask

    task automatic run_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL %s_drain: got %0d beats outstanding, exp 0", tag, exp_q.size());
        end
        repeat (4) cycle();
    endtask

    task automatic start_test(input bit cad, input int mode);
        chk_cad   = cad;
        have_prev = 0;
        rdy_mode  = mode;
    endtask

    initial begin
        int n;
        rst = 1'b0; sv = 3'b000; sl = 3'b000; m_tready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            sd[p] = '0; sk[p] = '0; su[p] = '0; gap_left[p] = -1;
        end
        @(negedge clk);
        repeat (3) cycle();

        // 1: reset state, then a lone net packet
        total++;
        assert (m_tvalid === 1'b0 && sr === 3'b000 && busy === 1'b0) else begin
            bad++;
            $error("FAIL reset_state: got valid=%0b treadys=%b busy=%0b, exp 0/000/0", m_tvalid, sr, busy);
        end
        rst = 1'b1;
        start_test(1, 1);
        add_pkt(2, 3, 'hA0, 0, -1, 0);
        drive_all();
        cycle();
        total++;
        assert (busy === 1'b1) else begin
            bad++;
            $error("FAIL t1_busy: got busy=%0b, exp 1", busy);
        end
        run_drain("t1", 50);

        // 2: all ports busy with 2-beat packets -> strict buf, ctl, net rotation
        start_test(1, 1);
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 3; p++) add_pkt(p, 2, -1, 0, -1, 0);
        drive_all();
        run_drain("t2", 100);

        // 5: single-beat packets, one beat every second cycle, tid 0,1,2,0
        start_test(1, 1);
        add_pkt(0, 1, -1, 0, -1, 0);
        add_pkt(1, 1, -1, 0, -1, 0);
        add_pkt(2, 1, -1, 0, -1, 0);
        add_pkt(0, 1, -1, 0, -1, 0);
        drive_all();
        run_drain("t5", 60);

        // 3: ctl packet under a backpressure pattern
        start_test(0, 1);
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        add_pkt(1, 4, -1, 0, -1, 0);
        drive_all();
        run_drain("t3", 60);

        // 4: net drops tvalid 3 cycles mid-packet while buf waits
        start_test(0, 1);
        add_pkt(2, 4, -1, 0, 2, 3);
        add_pkt(0, 2, -1, 0, -1, 0);
        drive_all();
        run_drain("t4", 80);

        // 6: reset during beat 2 of a 5-beat buf packet
        start_test(0, 0);
        add_pkt(0, 5, -1, 0, -1, 0);
        drive_all();
        n = 0;
        while (qsz(0) > 4 && n < 20) begin
            cycle();
            n++;
        end
        total++;
        assert (qsz(0) == 4) else begin
            bad++;
            $error("FAIL t6_reach_beat2: got %0d beats left, exp 4", qsz(0));
        end
        rst = 1'b0;
        cycle();
        total++;
        assert (m_tvalid === 1'b0 && busy === 1'b0 && sr === 3'b000) else begin
            bad++;
            $error("FAIL t6_reset: got valid=%0b busy=%0b treadys=%b, exp 0/0/000", m_tvalid, busy, sr);
        end
        rst = 1'b1;
        q0.delete(); q1.delete(); q2.delete(); exp_q.delete();
        sv = 3'b000;
        for (int p = 0; p < 3; p++) gap_left[p] = -1;
        start_test(1, 1);
        add_pkt(0, 1, -1, 0, -1, 0);
        add_pkt(1, 1, -1, 0, -1, 0);
        add_pkt(2, 1, -1, 0, -1, 0);
        drive_all();
        run_drain("t6", 60);

        // random traffic: every port always has a packet pending, so the
        // output must rotate buf, ctl, net with each packet contiguous
        start_test(0, 2);
        for (int k = 0; k < 20; k++)
            for (int p = 0; p < 3; p++)
                add_pkt(p, int'($urandom_range(1, 4)), -1, 1, -1, 0);
        drive_all();
        run_drain("rand", 5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
